// File: rtl/data_mem.sv
// Single-port word-organised data memory with valid/yumi handshake and one-cycle response.
module data_mem #(
  parameter int unsigned WORDS_P     = 1024,
  parameter string       INIT_FILE_P = "dmem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] port_flat_i,
  input  logic [31:0] addr,
  output logic [33:0] port_flat_o
);

  localparam int unsigned IDX_W = $clog2(WORDS_P);

  logic [31:0] mem [WORDS_P];

  logic        in_valid;
  logic        in_wen;
  logic        in_byte;
  logic [31:0] in_wdata;
  logic        in_yumi;

  logic        out_valid;
  logic [31:0] out_data;
  logic        accept;

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [31:0]      resp;

  assign in_valid = port_flat_i[35];
  assign in_wen   = port_flat_i[34];
  assign in_byte  = port_flat_i[33];
  assign in_wdata = port_flat_i[32:1];
  assign in_yumi  = port_flat_i[0];

  assign port_flat_o = {out_valid, out_data, accept};

  assign idx      = addr[IDX_W+1:2];
  assign lane     = addr[1:0];
  assign in_range = (addr[31:IDX_W+2] == '0);

  // Accept when idle or when the pending response is being consumed this cycle.
  assign accept = in_valid & ~(out_valid & ~in_yumi);

  always_comb begin
    rd_word = mem[idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    resp    = '0;
    if (in_wen)
      resp = in_byte ? {24'h000000, in_wdata[7:0]} : in_wdata;
    else if (in_range)
      resp = in_byte ? {24'h000000, rd_byte} : rd_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= resp;
    end else if (in_yumi) begin
      out_valid <= 1'b0;
    end
  end

  // Storage has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && accept && in_wen && in_range) begin
      if (in_byte)
        mem[idx][{lane, 3'b000} +: 8] <= in_wdata[7:0];
      else
        mem[idx] <= in_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic against a reference model.
module tb_data_mem;

    localparam int unsigned WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_v, in_w, in_b, in_y;
    logic [31:0] in_wd;
    logic [31:0] addr;
    logic [33:0] port_flat_o;

    logic        out_valid;
    logic [31:0] out_data;
    logic        out_yumi;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] ref_mem [WORDS];
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] pattern [WORDS];

    assign out_valid = port_flat_o[33];
    assign out_data  = port_flat_o[32:1];
    assign out_yumi  = port_flat_o[0];

    data_mem #(.WORDS_P(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .port_flat_i({in_v, in_w, in_b, in_wd, in_y}),
        .addr       (addr),
        .port_flat_o(port_flat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: inputs applied after a negedge, outputs checked at the next negedge.
    task automatic step(input logic v, input logic w, input logic b, input logic [31:0] wd,
                        input logic [31:0] a, input logic y, input logic rst);
        logic        acc;
        logic        inr;
        logic [31:0] resp;
        int unsigned idx, lane;
        in_v = v; in_w = w; in_b = b; in_wd = wd; addr = a; in_y = y; reset = rst;
        #1;
        acc  = v && !(exp_valid && !y);
        chk("accept", {31'd0, out_yumi}, {31'd0, acc});
        inr  = (a / 4) < WORDS;
        idx  = (a / 4) % WORDS;
        lane = a % 4;
        if (w)
            resp = b ? {24'd0, wd[7:0]} : wd;
        else if (!inr)
            resp = 32'd0;
        else
            resp = b ? ((ref_mem[idx] >> (8 * lane)) & 32'hFF) : ref_mem[idx];
        @(posedge clk);
        if (!rst) begin
            exp_valid = 1'b0;
            exp_data  = 32'd0;
        end else begin
            if (acc && w && inr) begin
                if (b)
                    ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * lane))) |
                                   ({24'd0, wd[7:0]} << (8 * lane));
                else
                    ref_mem[idx] = wd;
            end
            if (acc) begin
                exp_valid = 1'b1;
                exp_data  = resp;
            end else if (y) begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid || !rst)
            chk("read_data", out_data, exp_data);
    endtask

    initial begin
        logic v, w, b, y;
        logic [31:0] a, wd;
        exp_valid = 1'b0;
        exp_data  = 32'd0;
        in_v = 0; in_w = 0; in_b = 0; in_wd = 0; addr = 0; in_y = 0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);

        // Word loop: fill every word, then read back
        for (int i = 0; i < int'(WORDS); i++) begin
            pattern[i] = $urandom;
            step(1, 1, 0, pattern[i], 32'(4 * i), 1, 1);
            step(0, 0, 0, 0, 0, 1, 1);
        end
        for (int i = 0; i < int'(WORDS); i++) begin
            step(1, 0, 0, $urandom, 32'(4 * i), 1, 1);
            chk("word_loop", out_data, pattern[i]);
            step(0, 0, 0, 0, 0, 1, 1);
        end

        // Byte write / byte read
        step(1, 1, 0, 32'h11223344, 32'h10, 1, 1);
        step(1, 1, 1, 32'h555555AB, 32'h12, 1, 1);
        step(1, 0, 0, 0, 32'h10, 1, 1);
        chk("byte_merge", out_data, 32'h11AB3344);
        step(1, 0, 1, 0, 32'h13, 1, 1);
        chk("byte_read", out_data, 32'h00000011);
        step(0, 0, 0, 0, 0, 1, 1);

        // I/O window: acknowledged, echo write data, no storage effect
        step(1, 1, 0, 32'h1, 32'hDEADDEAD, 1, 1);
        chk("io_echo0", out_data, 32'h1);
        step(1, 1, 0, 32'h1, 32'h600DBEEF, 1, 1);
        step(1, 1, 0, 32'h1, 32'hC0DEC0DE, 1, 1);
        step(1, 0, 0, 0, 32'h00003FFC, 1, 1);
        chk("io_read_zero", out_data, 32'h0);
        step(1, 0, 0, 0, 32'h00000FFC, 1, 1);
        chk("io_alias_kept", out_data, pattern[WORDS-1]);
        step(0, 0, 0, 0, 0, 1, 1);

        // Stall: response held while yumi low, then streamed without a bubble
        step(1, 0, 0, 0, 32'h20, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 32'h24, 0, 1);
            chk("stall_hold", out_data, pattern[8]);
        end
        step(1, 0, 0, 0, 32'h24, 1, 1);
        chk("stream_next", out_data, pattern[9]);
        step(1, 0, 0, 0, 32'h28, 1, 1);
        chk("stream_next2", out_data, pattern[10]);
        step(0, 0, 0, 0, 0, 1, 1);

        // Reset mid-op: pending response dropped, storage retained, request ignored
        step(1, 1, 0, 32'hCAFEF00D, 32'h30, 0, 1);
        step(1, 1, 0, 32'h0BADBEEF, 32'h30, 1, 0);
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        step(1, 0, 0, 0, 32'h30, 1, 1);
        chk("midreset_kept", out_data, 32'hCAFEF00D);
        step(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1);
            b  = $urandom_range(0, 1);
            y  = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            if ($urandom_range(0, 9) == 0)
                a = $urandom | 32'h00010000;
            else
                a = 32'($urandom_range(0, 4 * WORDS - 1));
            if (!b)
                a = a & ~32'h3;
            step(v, w, b, wd, a, y, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
